// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
// The fetch unit is the master: it holds IMemReq/IMemAddr until the memory acknowledges.
interface inst_fetch_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemRdata
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemRdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request feeding a 2-entry in-order
// {PC4, Inst} buffer that the IF/ID register drains under hazard-unit control.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         HzCtrl,
    input  logic               Redirect,
    input  logic [31:0]        RedirectPC,
    inst_fetch_if.master       imem,
    output logic [31:0]        Inst,
    output logic [31:0]        PC4,
    output logic               InstValid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;

    logic        push;
    logic        pop;
    logic        tail;
    logic [1:0]  count_after;
    logic [31:0] redirect_tgt;
    logic [31:0] req_addr_inc;
    logic [31:0] entry_inst [2];
    logic [31:0] entry_pc4  [2];

    assign redirect_tgt = {RedirectPC[31:2], 2'b00};
    assign req_addr_inc = req_addr_q + 32'd4;

    assign InstValid = (count_q != 2'd0);
    assign pop       = InstValid && !HzCtrl[1];
    assign push      = (state_q == REQ) && imem.IMemAck && !Redirect;
    // A push only happens in REQ, where at most one entry is held, so head^count[0] is the free slot.
    assign tail        = head_q ^ count_q[0];
    assign count_after = count_q + {1'b0, push} - {1'b0, pop};

    assign Inst          = InstValid ? entry_inst[head_q] : 32'h0;
    assign PC4           = InstValid ? entry_pc4[head_q]  : 32'h0;
    assign imem.IMemReq  = (state_q != IDLE);
    assign imem.IMemAddr = req_addr_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [31:0] inst_q;
            logic [31:0] pc4_q;

            always_ff @(posedge clk) begin
                if (push && (tail == 1'(gi))) begin
                    inst_q <= imem.IMemRdata;
                    pc4_q  <= req_addr_inc;
                end
            end

            assign entry_inst[gi] = inst_q;
            assign entry_pc4[gi]  = pc4_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        count_d    = count_after;
        head_d     = pop ? ~head_q : head_q;

        if (Redirect) begin
            // The old request, if any, must still complete on the bus; its data is never kept.
            count_d    = 2'd0;
            fetch_pc_d = redirect_tgt;
            case (state_q)
                IDLE: begin
                    state_d    = REQ;
                    req_addr_d = redirect_tgt;
                end
                REQ, DROP: begin
                    if (imem.IMemAck) begin
                        state_d    = REQ;
                        req_addr_d = redirect_tgt;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < 2'd2) begin
                        state_d    = REQ;
                        req_addr_d = fetch_pc_q;
                    end
                end
                REQ: begin
                    if (imem.IMemAck) begin
                        fetch_pc_d = req_addr_inc;
                        if (count_after < 2'd2) begin
                            req_addr_d = req_addr_inc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem.IMemAck) begin
                        state_d    = REQ;
                        req_addr_d = fetch_pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 HzCtrl  input  2  from hazard unit, same encoding as the IF/ID register: 00 normal, 01 flush, 10 stall, 11 treated as stall.
REQ-005 Redirect  input  1  taken branch/jump this cycle.
REQ-006 RedirectPC  input  32  new fetch address; bits [1:0] ignored.
REQ-007 IMemReq  output  1  instruction memory read request.
REQ-008 IMemAddr  output  32  request address, word aligned.
REQ-009 IMemAck  input  1  memory returns IMemRdata this cycle; latency 0..N cycles after request.
REQ-010 IMemRdata  input  32  instruction word, valid when IMemAck=1.
REQ-011 Inst  output  32  instruction word at FIFO head, to IF/ID Inst.
REQ-012 PC4  output  32  address+4 of head instruction, to IF/ID PC4.
REQ-013 InstValid  output  1  FIFO head valid; hazard unit bubbles IF/ID when 0.

Function
REQ-014 Internal 2-entry in-order FIFO of {PC4, Inst}; Inst/PC4/InstValid driven from head; when empty Inst=0 (NOP), PC4=0, InstValid=0.
REQ-015 Pop at posedge when InstValid=1 and HzCtrl is 00 or 01; no pop when HzCtrl is 10 or 11.
REQ-016 States IDLE, REQ, DROP; registers FetchPC, ReqAddr, count (0..2).
REQ-017 IDLE: IMemReq=0; if Redirect=0 and count<2, latch ReqAddr=FetchPC and enter REQ next cycle.
REQ-018 REQ/DROP: IMemReq=1 and IMemAddr=ReqAddr, held stable every cycle until IMemAck=1.
REQ-019 REQ with IMemAck=1 and Redirect=0: push {ReqAddr+4, IMemRdata}, FetchPC=ReqAddr+4; if count after push/pop <2, stay REQ with ReqAddr=ReqAddr+4 (back-to-back), else go IDLE.
REQ-020 With zero-wait memory (ack in the request cycle) and HzCtrl=00, throughput is one instruction per cycle.
REQ-021 At most one request outstanding; count never exceeds 2; a push and a pop in the same cycle leave count unchanged.
REQ-022 Redirect has priority over push and pop: FIFO cleared (count=0), FetchPC={RedirectPC[31:2],2'b00}.
REQ-023 Redirect in IDLE: next state REQ with ReqAddr=redirect target.
REQ-024 Redirect in REQ with IMemAck=1: returned data discarded; next state REQ at redirect target.
REQ-025 Redirect in REQ with IMemAck=0: enter DROP and keep the old request asserted until ack.
REQ-026 DROP with IMemAck=1: data discarded; next state REQ at FetchPC.
REQ-027 Redirect in DROP: FetchPC updated; stay DROP.
REQ-028 IMemAck in IDLE ignored.
REQ-029 Address arithmetic modulo 2^32: 0xFFFFFFFC+4 = 0x00000000.

Reset
REQ-030 While rst=0, asynchronously: state=IDLE, FetchPC=RESET_PC, ReqAddr=RESET_PC, count=0, IMemReq=0, IMemAddr=RESET_PC, Inst=0, PC4=0, InstValid=0.
REQ-031 Reset during an outstanding request abandons it; an IMemAck in the first cycle after release is ignored.
REQ-032 First request (address RESET_PC) asserts in the second cycle after rst deasserts (IDLE -> REQ).

Verification
REQ-033 Zero-wait memory, HzCtrl=00 -> IMemAddr 0x0, 0x4, 0x8 on consecutive cycles; InstValid=1 from the cycle after the first ack; PC4 sequence 0x4, 0x8, 0xC.
REQ-034 3-cycle memory latency -> IMemReq/IMemAddr held 3 cycles per fetch; one InstValid instruction per 3 cycles; no duplicates.
REQ-035 Zero-wait, HzCtrl=10 for 4 cycles -> count reaches 2, IMemReq drops, Inst/PC4 hold; on HzCtrl=00 entries emerge in order with no loss or duplication.
REQ-036 Request to 0x8 outstanding (2-cycle latency), Redirect to 0x00001000 -> IMemReq stays at 0x8 until ack, data discarded, InstValid=0, next request 0x1000, then PC4=0x1004.
REQ-037 Redirect, ack and pop in the same cycle -> count=0 next cycle; next IMemAddr equals the target; no stale instruction appears.
REQ-038 Redirect to 0xFFFFFFFC -> instruction delivered with PC4=0x00000000; next fetch at 0x00000000.
